// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use / branch-operand stall detection, DEC and EXE
// forwarding selects, and the mult/div busy sequencer that guards HI/LO readers.
module hazard_unit #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_DEC,
    input  logic [4:0] rt_DEC,
    input  logic [4:0] rs_EXE,
    input  logic [4:0] rt_EXE,
    input  logic [4:0] writereg_EXE,
    input  logic [4:0] writereg_MEM,
    input  logic [4:0] writereg_WB,
    input  logic       regwrite_EXE,
    input  logic       regwrite_MEM,
    input  logic       regwrite_WB,
    input  logic       memtoreg_EXE,
    input  logic       memtoreg_MEM,
    input  logic       branch_DEC,
    input  logic       pcsrc_DEC,
    input  logic       md_start_DEC,
    input  logic       md_start_EXE,
    input  logic       md_is_div_EXE,
    input  logic       mfhilo_DEC,
    output logic       stall_F,
    output logic       stall_D,
    output logic       flush_D,
    output logic       clear_E,
    output logic       forwardA_D,
    output logic       forwardB_D,
    output logic [1:0] forwardA_E,
    output logic [1:0] forwardB_E,
    output logic       md_busy,
    output logic       md_done
);

    localparam int unsigned REG_W = 5;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    md_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             done_q, done_n;

    logic             lwstall;
    logic             brstall;
    logic             mdstall;
    logic             stall;

    // Writer match; $0 is hardwired so a destination of zero never matches.
    function automatic logic reg_hit(input logic we,
                                     input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] src);
        return we && (dst != '0) && (dst == src);
    endfunction

    // mult/div sequencer state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            done_q <= done_n;
        end
    end

    // mult/div next state: count down the latency, pulse done on the way back to IDLE
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (md_start_EXE) begin
                    state_n = BUSY;
                    cnt_n   = md_is_div_EXE ? DIV_LOAD : MUL_LOAD;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // hazard detection and forwarding; everything is held at zero while in reset
    always_comb begin
        lwstall    = 1'b0;
        brstall    = 1'b0;
        mdstall    = 1'b0;
        stall      = 1'b0;
        stall_F    = 1'b0;
        stall_D    = 1'b0;
        flush_D    = 1'b0;
        clear_E    = 1'b0;
        forwardA_D = 1'b0;
        forwardB_D = 1'b0;
        forwardA_E = 2'b00;
        forwardB_E = 2'b00;
        md_busy    = 1'b0;
        md_done    = 1'b0;
        if (reset) begin
            lwstall = memtoreg_EXE && ((rt_EXE == rs_DEC) || (rt_EXE == rt_DEC));
            brstall = branch_DEC &&
                      (reg_hit(regwrite_EXE, writereg_EXE, rs_DEC) ||
                       reg_hit(regwrite_EXE, writereg_EXE, rt_DEC) ||
                       reg_hit(memtoreg_MEM, writereg_MEM, rs_DEC) ||
                       reg_hit(memtoreg_MEM, writereg_MEM, rt_DEC));
            mdstall = (state == BUSY) && (mfhilo_DEC || md_start_DEC);
            stall   = lwstall || brstall || mdstall;

            stall_F = stall;
            stall_D = stall;
            clear_E = stall;
            // a redirect must not discard an instruction that DEC is still holding
            flush_D = pcsrc_DEC && !stall;

            forwardA_D = reg_hit(regwrite_MEM, writereg_MEM, rs_DEC);
            forwardB_D = reg_hit(regwrite_MEM, writereg_MEM, rt_DEC);

            // MEM is the younger result, so it wins over WB
            if (reg_hit(regwrite_MEM, writereg_MEM, rs_EXE)) begin
                forwardA_E = 2'b10;
            end else if (reg_hit(regwrite_WB, writereg_WB, rs_EXE)) begin
                forwardA_E = 2'b01;
            end
            if (reg_hit(regwrite_MEM, writereg_MEM, rt_EXE)) begin
                forwardB_E = 2'b10;
            end else if (reg_hit(regwrite_WB, writereg_WB, rt_EXE)) begin
                forwardB_E = 2'b01;
            end

            md_busy = (state == BUSY);
            md_done = done_q;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a table of combinational hazard/forward vectors
// plus scoreboarded multi-cycle mult/div and reset sequences.
module tb_hazard_unit;

    logic       clk;
    logic       reset;
    logic [4:0] rs_DEC, rt_DEC, rs_EXE, rt_EXE;
    logic [4:0] writereg_EXE, writereg_MEM, writereg_WB;
    logic       regwrite_EXE, regwrite_MEM, regwrite_WB;
    logic       memtoreg_EXE, memtoreg_MEM;
    logic       branch_DEC, pcsrc_DEC;
    logic       md_start_DEC, md_start_EXE, md_is_div_EXE, mfhilo_DEC;
    logic       stall_F, stall_D, flush_D, clear_E;
    logic       forwardA_D, forwardB_D;
    logic [1:0] forwardA_E, forwardB_E;
    logic       md_busy, md_done;

    logic [11:0] outs;
    assign outs = {stall_F, stall_D, flush_D, clear_E, forwardA_D, forwardB_D,
                   forwardA_E, forwardB_E, md_busy, md_done};

    hazard_unit #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .rs_DEC       (rs_DEC),
        .rt_DEC       (rt_DEC),
        .rs_EXE       (rs_EXE),
        .rt_EXE       (rt_EXE),
        .writereg_EXE (writereg_EXE),
        .writereg_MEM (writereg_MEM),
        .writereg_WB  (writereg_WB),
        .regwrite_EXE (regwrite_EXE),
        .regwrite_MEM (regwrite_MEM),
        .regwrite_WB  (regwrite_WB),
        .memtoreg_EXE (memtoreg_EXE),
        .memtoreg_MEM (memtoreg_MEM),
        .branch_DEC   (branch_DEC),
        .pcsrc_DEC    (pcsrc_DEC),
        .md_start_DEC (md_start_DEC),
        .md_start_EXE (md_start_EXE),
        .md_is_div_EXE(md_is_div_EXE),
        .mfhilo_DEC   (mfhilo_DEC),
        .stall_F      (stall_F),
        .stall_D      (stall_D),
        .flush_D      (flush_D),
        .clear_E      (clear_E),
        .forwardA_D   (forwardA_D),
        .forwardB_D   (forwardB_D),
        .forwardA_E   (forwardA_E),
        .forwardB_E   (forwardB_E),
        .md_busy      (md_busy),
        .md_done      (md_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic       rw_e, rw_m, rw_w, mtr_e, mtr_m, br, pcs;
        logic       stall, flush, fad, fbd;
        logic [1:0] fae, fbe;
    } vec_t;

    typedef struct {
        string       name;
        logic [11:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input string nm,
                                input logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w,
                                input logic rw_e, rw_m, rw_w, mtr_e, mtr_m, br, pcs,
                                input logic stall, flush, fad, fbd,
                                input logic [1:0] fae, fbe);
        vec_t v;
        v.name = nm;
        v.rs_d = rs_d; v.rt_d = rt_d; v.rs_e = rs_e; v.rt_e = rt_e;
        v.wr_e = wr_e; v.wr_m = wr_m; v.wr_w = wr_w;
        v.rw_e = rw_e; v.rw_m = rw_m; v.rw_w = rw_w;
        v.mtr_e = mtr_e; v.mtr_m = mtr_m; v.br = br; v.pcs = pcs;
        v.stall = stall; v.flush = flush; v.fad = fad; v.fbd = fbd;
        v.fae = fae; v.fbe = fbe;
        return v;
    endfunction

    function automatic logic [11:0] pack(input logic stall, flush, fad, fbd,
                                         input logic [1:0] fae, fbe,
                                         input logic busy, done);
        return {stall, stall, flush, stall, fad, fbd, fae, fbe, busy, done};
    endfunction

    task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b  {sF sD fD cE fAD fBD fAE fBE busy done}",
                     nm, act, exp);
        end
    endtask

    task automatic set_idle();
        rs_DEC = 5'd1; rt_DEC = 5'd2; rs_EXE = 5'd10; rt_EXE = 5'd11;
        writereg_EXE = 5'd20; writereg_MEM = 5'd21; writereg_WB = 5'd22;
        regwrite_EXE = 1'b0; regwrite_MEM = 1'b0; regwrite_WB = 1'b0;
        memtoreg_EXE = 1'b0; memtoreg_MEM = 1'b0;
        branch_DEC = 1'b0; pcsrc_DEC = 1'b0;
        md_start_DEC = 1'b0; md_start_EXE = 1'b0; md_is_div_EXE = 1'b0; mfhilo_DEC = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        rs_DEC = v.rs_d; rt_DEC = v.rt_d; rs_EXE = v.rs_e; rt_EXE = v.rt_e;
        writereg_EXE = v.wr_e; writereg_MEM = v.wr_m; writereg_WB = v.wr_w;
        regwrite_EXE = v.rw_e; regwrite_MEM = v.rw_m; regwrite_WB = v.rw_w;
        memtoreg_EXE = v.mtr_e; memtoreg_MEM = v.mtr_m;
        branch_DEC = v.br; pcsrc_DEC = v.pcs;
    endtask

    // One mult/div launch; cycle c is the period after the c-th edge following the launch
    // cycle. Expected busy for c in 1..N, done at c==N+1, everything dead from rst_c on.
    task automatic md_run(input string tag, input logic is_div, input logic rd_hilo,
                          input logic dec_md, input logic fwd, input int rst_c);
        int          n;
        logic        killed, in_rst, busy, done, stall;
        logic [1:0]  fae;
        sb_t         e;
        n = is_div ? 32 : 4;
        for (int c = 0; c <= n + 2; c++) begin
            @(posedge clk);
            #1;
            in_rst        = (rst_c != 0) && (c == rst_c);
            killed        = (rst_c != 0) && (c >= rst_c);
            md_start_EXE  = (c == 0);
            md_is_div_EXE = is_div;
            mfhilo_DEC    = rd_hilo;
            md_start_DEC  = dec_md;
            rs_EXE        = fwd ? 5'd5 : 5'd10;
            writereg_MEM  = fwd ? 5'd5 : 5'd21;
            regwrite_MEM  = fwd;
            reset         = !in_rst;
            busy  = !killed && (c >= 1) && (c <= n);
            done  = !killed && (c == n + 1);
            stall = busy && (rd_hilo || dec_md);
            fae   = (fwd && !in_rst) ? 2'b10 : 2'b00;
            e.name = $sformatf("%s_c%0d", tag, c);
            e.exp  = pack(stall, 1'b0, 1'b0, 1'b0, fae, 2'b00, busy, done);
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        set_idle();
    endtask

    // scoreboard consumer: compares the expectation pushed for the current cycle
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check(e.name, outs, e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs.push_back(mk("idle",        1,2,10,11,20,21,22, 0,0,0,0,0,0,0, 0,0,0,0,2'b00,2'b00));
        vecs.push_back(mk("fwdA_E_mem",  1,2, 5,11,20, 5, 5, 0,1,1,0,0,0,0, 0,0,0,0,2'b10,2'b00));
        vecs.push_back(mk("fwdA_E_wb",   1,2, 5,11,20, 5, 5, 0,0,1,0,0,0,0, 0,0,0,0,2'b01,2'b00));
        vecs.push_back(mk("fwd_r0",      0,2, 0,11,20, 0, 0, 0,1,1,0,0,0,0, 0,0,0,0,2'b00,2'b00));
        vecs.push_back(mk("fwdB_E_mem",  1,2,22, 7,20, 7,22, 0,1,1,0,0,0,0, 0,0,0,0,2'b01,2'b10));
        vecs.push_back(mk("fwd_D",       9,9,10,11,20, 9,22, 0,1,0,0,0,0,0, 0,0,1,1,2'b00,2'b00));
        vecs.push_back(mk("fwd_D_norw",  9,9,10,11,20, 9,22, 0,0,0,0,0,0,0, 0,0,0,0,2'b00,2'b00));
        vecs.push_back(mk("lw_rs",       8,2,10, 8,20,21,22, 0,0,0,1,0,0,0, 1,0,0,0,2'b00,2'b00));
        vecs.push_back(mk("lw_rt",       1,8,10, 8,20,21,22, 0,0,0,1,0,0,0, 1,0,0,0,2'b00,2'b00));
        vecs.push_back(mk("lw_none",     1,2,10, 8,20,21,22, 0,0,0,1,0,0,0, 0,0,0,0,2'b00,2'b00));
        vecs.push_back(mk("br_exe",      3,2,10,11, 3,21,22, 1,0,0,0,0,1,0, 1,0,0,0,2'b00,2'b00));
        vecs.push_back(mk("br_mem_fwd",  3,2,10,11,20, 3,22, 0,1,0,0,0,1,0, 0,0,1,0,2'b00,2'b00));
        vecs.push_back(mk("br_mem_load", 1,4,10,11,20, 4,22, 0,1,0,0,1,1,0, 1,0,0,1,2'b00,2'b00));
        vecs.push_back(mk("br_r0",       0,2,10,11, 0,21,22, 1,0,0,0,0,1,0, 0,0,0,0,2'b00,2'b00));
        vecs.push_back(mk("br_exe_norw", 3,2,10,11, 3,21,22, 0,0,0,0,0,1,0, 0,0,0,0,2'b00,2'b00));
        vecs.push_back(mk("nobr_exe",    3,2,10,11, 3,21,22, 1,0,0,0,0,0,0, 0,0,0,0,2'b00,2'b00));
        vecs.push_back(mk("flush_lw",    8,2,10, 8,20,21,22, 0,0,0,1,0,0,1, 1,0,0,0,2'b00,2'b00));
        vecs.push_back(mk("flush",       8,2,10, 8,20,21,22, 0,0,0,0,0,0,1, 0,1,0,0,2'b00,2'b00));

        // reset holds every output low even with a live forwarding match
        set_idle();
        reset = 1'b0;
        rs_EXE = 5'd5; writereg_MEM = 5'd5; regwrite_MEM = 1'b1;
        mfhilo_DEC = 1'b1; memtoreg_EXE = 1'b1; rt_EXE = 5'd1; pcsrc_DEC = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("reset_outputs", outs, 12'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        set_idle();
        #2;

        foreach (vecs[i]) begin
            apply_vec(vecs[i]);
            #1;
            check(vecs[i].name,
                  outs,
                  pack(vecs[i].stall, vecs[i].flush, vecs[i].fad, vecs[i].fbd,
                       vecs[i].fae, vecs[i].fbe, 1'b0, 1'b0));
            #9;
        end
        set_idle();

        md_run("mult_b2b",  1'b0, 1'b0, 1'b1, 1'b0, 0);
        md_run("div_mflo",  1'b1, 1'b1, 1'b0, 1'b0, 0);
        md_run("mult_rst",  1'b0, 1'b1, 1'b0, 1'b1, 2);
        md_run("mult_post", 1'b0, 1'b1, 1'b0, 1'b0, 0);

        repeat (2) @(posedge clk);
        #3;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
